// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states, byte/half/word
// access with lane merge and sign/zero extension. Optional mailbox: `define DMEM_TOHOST_EN.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] TOHOST_ADDR = 32'hFFFF_FFFC
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
`ifdef DMEM_TOHOST_EN
  ,
  output logic [31:0] tohost,
  output logic        tohost_valid
`endif
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
  } req_t;

  state_t      state;
  req_t        r;
  logic [3:0]  cnt;
  logic [31:0] mem [DEPTH_WORDS];

  logic [4:0]  sh;
  logic [31:0] rd, rsh, mask, merged, ld;
  logic        err, th_hit, exec;

  // Decode of the latched request; only consumed on the access edge.
  always_comb begin
    th_hit = (r.addr == TOHOST_ADDR);
    sh     = {r.addr[1:0], 3'b000};
    rd     = mem[r.addr[AW+1:2]];
    rsh    = rd >> sh;
    err    = (r.size == 2'b11) ||
             (r.size == 2'b01 && r.addr[0]) ||
             (r.size == 2'b10 && r.addr[1:0] != 2'b00);
`ifdef DMEM_TOHOST_EN
    if (th_hit) err = (r.size != 2'b10);
    else        err = err || ({2'b00, r.addr[31:2]} >= 32'(DEPTH_WORDS));
`else
    // Without a mailbox the address is just another out-of-range fault.
    err = err || th_hit || ({2'b00, r.addr[31:2]} >= 32'(DEPTH_WORDS));
`endif
    case (r.size)
      2'b00: begin
        mask = 32'h0000_00FF;
        ld   = r.uns ? {24'h0, rsh[7:0]} : {{24{rsh[7]}}, rsh[7:0]};
      end
      2'b01: begin
        mask = 32'h0000_FFFF;
        ld   = r.uns ? {16'h0, rsh[15:0]} : {{16{rsh[15]}}, rsh[15:0]};
      end
      default: begin
        mask = 32'hFFFF_FFFF;
        ld   = rsh;
      end
    endcase
    mask   = mask << sh;
    merged = (rd & ~mask) | ((r.wdata << sh) & mask);
  end

  assign exec = (state == WAIT) && (cnt == 4'd0);

  // RAM has no reset; reset forces IDLE so a dropped store never writes.
  always_ff @(posedge clk) begin
    if (exec && r.we && !err && !th_hit) mem[r.addr[AW+1:2]] <= merged;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      r         <= '0;
      cnt       <= 4'd0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
`ifdef DMEM_TOHOST_EN
      tohost       <= 32'h0;
      tohost_valid <= 1'b0;
`endif
    end else begin
`ifdef DMEM_TOHOST_EN
      tohost_valid <= 1'b0;
`endif
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            r         <= '{we: req_we, addr: req_addr, wdata: req_wdata,
                           size: req_size, uns: req_unsigned};
            cnt       <= 4'(WAIT_CYCLES);
            req_ready <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= err;
            rsp_rdata <= (err || r.we) ? 32'h0 : ld;
`ifdef DMEM_TOHOST_EN
            if (th_hit && !err) begin
              if (r.we) begin
                tohost       <= r.wdata;
                tohost_valid <= 1'b1;
              end else begin
                rsp_rdata <= tohost;
              end
            end
`endif
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed table-driven bench for dmem_responder plus hand sequences for
// back-pressure, mid-transaction reset and (when enabled) the mailbox.
module tb_dmem_responder;
  localparam int W     = 2;
  localparam int DEPTH = 256;
  localparam logic [31:0] TH = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_unsigned = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = 2'b10;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_rdata;
`ifdef DMEM_TOHOST_EN
  logic [31:0] tohost;
  logic        tohost_valid;
  int          th_pulses = 0;
  always @(negedge clk) if (tohost_valid) th_pulses++;
`endif

  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W), .TOHOST_ADDR(TH)) dut (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
`ifdef DMEM_TOHOST_EN
    , .tohost(tohost), .tohost_valid(tohost_valid)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Accept at a posedge; latency counts the accept edge as edge 1.
  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input logic u);
    int n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) chk("ready_timeout", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
    req_size = sz; req_unsigned = u;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 40) begin @(posedge clk); lat++; @(negedge clk); end
    if (!rsp_valid) chk("rsp_timeout", 32'(rsp_valid), 32'd1);
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [1:0] sz, input logic u,
                     output logic [31:0] rd, output logic e, output int lat);
    issue(we, a, wd, sz, u);
    wait_rsp(lat);
    rd = rsp_rdata; e = rsp_err;
    finish_rsp();
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vt[$];

  initial begin
    logic [31:0] rd, held;
    logic        e;
    int          lat;

    vt.push_back('{"sw_dead",   1'b1, 32'h10,  32'hDEADBEEF, 2'b10, 1'b0, 32'h0,        1'b0});
    vt.push_back('{"lw_dead",   1'b0, 32'h10,  32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 1'b0});
    vt.push_back('{"sw_zero",   1'b1, 32'h10,  32'h0,        2'b10, 1'b0, 32'h0,        1'b0});
    vt.push_back('{"sb_80",     1'b1, 32'h11,  32'h80,       2'b00, 1'b0, 32'h0,        1'b0});
    vt.push_back('{"lbu_11",    1'b0, 32'h11,  32'h0,        2'b00, 1'b1, 32'h00000080, 1'b0});
    vt.push_back('{"lb_11",     1'b0, 32'h11,  32'h0,        2'b00, 1'b0, 32'hFFFFFF80, 1'b0});
    vt.push_back('{"lw_8000",   1'b0, 32'h10,  32'h0,        2'b10, 1'b0, 32'h00008000, 1'b0});
    vt.push_back('{"sh_beef",   1'b1, 32'h12,  32'h1234BEEF, 2'b01, 1'b0, 32'h0,        1'b0});
    vt.push_back('{"lw_merge",  1'b0, 32'h10,  32'h0,        2'b10, 1'b0, 32'hBEEF8000, 1'b0});
    vt.push_back('{"lh_12",     1'b0, 32'h12,  32'h0,        2'b01, 1'b0, 32'hFFFFBEEF, 1'b0});
    vt.push_back('{"lhu_12",    1'b0, 32'h12,  32'h0,        2'b01, 1'b1, 32'h0000BEEF, 1'b0});
    vt.push_back('{"lh_mis",    1'b0, 32'h13,  32'h0,        2'b01, 1'b0, 32'h0,        1'b1});
    vt.push_back('{"sw_mis",    1'b1, 32'h12,  32'h11111111, 2'b10, 1'b0, 32'h0,        1'b1});
    vt.push_back('{"lw_nochg",  1'b0, 32'h10,  32'h0,        2'b10, 1'b1, 32'hBEEF8000, 1'b0});
    vt.push_back('{"sb_hi",     1'b1, 32'h13,  32'hFFFFFF7F, 2'b00, 1'b0, 32'h0,        1'b0});
    vt.push_back('{"lw_sbhi",   1'b0, 32'h10,  32'h0,        2'b10, 1'b0, 32'h7FEF8000, 1'b0});
    vt.push_back('{"sw_oor",    1'b1, 32'h400, 32'h1,        2'b10, 1'b0, 32'h0,        1'b1});
    vt.push_back('{"lw_oor",    1'b0, 32'h400, 32'h0,        2'b10, 1'b0, 32'h0,        1'b1});
    vt.push_back('{"ld_sz3",    1'b0, 32'h10,  32'h0,        2'b11, 1'b0, 32'h0,        1'b1});
    vt.push_back('{"sw_last",   1'b1, 32'h3FC, 32'hCAFEF00D, 2'b10, 1'b0, 32'h0,        1'b0});
    vt.push_back('{"lw_last",   1'b0, 32'h3FC, 32'h0,        2'b10, 1'b0, 32'hCAFEF00D, 1'b0});
`ifndef DMEM_TOHOST_EN
    vt.push_back('{"sw_th_oor", 1'b1, TH,      32'h1,        2'b10, 1'b0, 32'h0,        1'b1});
`endif

    // Reset state
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata",     rsp_rdata,      32'h0);
    chk("rst_err",       32'(rsp_err),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      txn(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].sz, vt[i].u, rd, e, lat);
      chk({vt[i].name, "_rdata"}, rd, vt[i].exp_rd);
      chk({vt[i].name, "_err"}, 32'(e), 32'(vt[i].exp_err));
      chk({vt[i].name, "_lat"}, 32'(lat), 32'(W + 2));
    end

    // Back-pressure: response held, competing request must not be taken
    issue(1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
    wait_rsp(lat);
    held = rsp_rdata;
    chk("bp_first", held, 32'h7FEF8000);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_size = 2'b10;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rdata", rsp_rdata, held);
      chk("bp_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    finish_rsp();
    repeat (5) @(negedge clk);
    chk("bp_no_accept", 32'(rsp_valid), 32'd0);
    txn(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, e, lat);
    chk("bp_mem_intact", rd, 32'h7FEF8000);

    // Reset during WAIT drops the store
    txn(1'b1, 32'h20, 32'h55AA55AA, 2'b10, 1'b0, rd, e, lat);
    issue(1'b1, 32'h20, 32'h12345678, 2'b10, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_rdata", rsp_rdata,      32'h0);
    chk("mid_rst_err",   32'(rsp_err),   32'd0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    txn(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, rd, e, lat);
    chk("mid_rst_mem", rd, 32'h55AA55AA);
    chk("mid_rst_lat", 32'(lat), 32'(W + 2));

`ifdef DMEM_TOHOST_EN
    chk("th_reset", tohost, 32'h0);
    txn(1'b1, TH, 32'h1, 2'b10, 1'b0, rd, e, lat);
    chk("th_sw_err",    32'(e),      32'd0);
    chk("th_value",     tohost,      32'h1);
    chk("th_pulses",    32'(th_pulses), 32'd1);
    txn(1'b1, TH, 32'hAB, 2'b00, 1'b0, rd, e, lat);
    chk("th_sb_err",    32'(e),      32'd1);
    chk("th_sb_keep",   tohost,      32'h1);
    chk("th_sb_pulses", 32'(th_pulses), 32'd1);
    txn(1'b0, TH, 32'h0, 2'b10, 1'b0, rd, e, lat);
    chk("th_lw",        rd,          32'h1);
    chk("th_lw_err",    32'(e),      32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
